uart_receiver: RTL
==================

Name: uart_receiver

Overview:
Serial-to-parallel UART receive stage. It sits directly upstream of the main controller and feeds that controller's receive-data, frame-error and parity-error inputs. It synchronises the asynchronous RX line and detects a valid start bit. It then samples data, parity and stop bits at mid-bit using a 16x oversampling tick and publishes each received character with one-cycle done/error flags.

Parameters:
OVERSAMPLE, 16, ticks of ov_tick_i per bit period; must be a power of two, >= 8
SYNC_STAGES, 2, flip-flops in the RX line synchroniser; >= 2

Ports:
clk_i  input  1  system clock; all logic on rising edge
rst_i  input  1  asynchronous, active-high reset
rx_i  input  1  serial line, asynchronous to clk_i, idle high
rx_enable_i  input  1  receiver enable
ov_tick_i  input  1  one-cycle pulse, OVERSAMPLE per bit period, from baud generator
data_width_i  input  2  00=5, 01=6, 10=7, 11=8 data bits
parity_mode_i  input  2  00=none, 01=even, 10=odd, 11=none
stop_bits_i  input  1  0=one stop bit, 1=two stop bits
data_rx_o  output  8  last received character, LSB-aligned, unused MSBs zero
rx_done_o  output  1  one-cycle pulse: new character on data_rx_o
frame_error_o  output  1  valid with rx_done_o: a stop bit was sampled low
parity_error_o  output  1  valid with rx_done_o: parity mismatch
rx_busy_o  output  1  high from start-edge detection until return to IDLE

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: synchroniser FFs = 1, state = IDLE, data_rx_o = 8'h00, rx_done_o/frame_error_o/parity_error_o/rx_busy_o = 0, all counters = 0.
- rx_i passes through SYNC_STAGES FFs. Edge detection uses the synchronised value and its one-cycle-delayed copy. All line samples below refer to the synchronised value.
- Tick counter: log2(OVERSAMPLE) bits. It advances only on clock cycles with ov_tick_i = 1.
- IDLE:
  - On a synchronised 1->0 edge with rx_enable_i = 1: latch data_width_i, parity_mode_i and stop_bits_i into internal registers; clear the tick counter; go to START; set rx_busy_o.
  - Config changes after this latch have no effect until the next frame.
- START:
  - On the tick at which the counter reaches OVERSAMPLE/2-1, sample the line.
  - Sample 0: clear the counter and bit index, go to DATA.
  - Sample 1: glitch; return to IDLE with no flags.
- DATA:
  - Sample every OVERSAMPLE ticks, i.e. on the tick where the counter wraps from OVERSAMPLE-1 to 0.
  - Shift in LSB first; the bit index counts 0..N-1.
  - After bit N-1: go to PARITY if parity is enabled, else STOP.
- PARITY:
  - Sample one bit. Expected value: XOR of the N data bits (even), or its inverse (odd).
  - Mismatch sets an internal parity-error flag. Go to STOP.
- STOP:
  - Sample one bit (or two consecutive bits if the latched stop_bits = 1). Any stop sample = 0 sets an internal frame-error flag.
  - The second stop bit is still sampled even if the first was 0.
- Publish: in the clock cycle after the last stop sample, for exactly one cycle:
  - data_rx_o <= received bits zero-extended; rx_done_o = 1.
  - frame_error_o and parity_error_o = the internal flags.
  - Go to IDLE; rx_busy_o = 0.
  - Internal flags clear on the next start detection.
- data_rx_o holds its value between frames. frame_error_o and parity_error_o are 0 whenever rx_done_o = 0.
- A start edge can be detected in the cycle immediately after returning to IDLE (back-to-back frames).
- After a frame error with the line still low, no new frame starts until a fresh 1->0 edge.
- rx_enable_i = 0 in any non-IDLE state: abort to IDLE on the next clock. No rx_done_o, data_rx_o unchanged, rx_busy_o = 0.
- rst_i asserted mid-frame: immediate return to reset values. No done pulse after release.
- Cycles without ov_tick_i: state and counters hold.
- Character latency from the start edge: (1 + N + P + S) x OVERSAMPLE − OVERSAMPLE/2 ticks, then +1 clock to rx_done_o, plus synchroniser delay. N = data bits; P = 0/1 parity; S = 1/2 stop bits.

Test Plan:
- 8N1, 0xA5 sent LSB first at 16 ticks/bit -> one rx_done_o pulse, data_rx_o = 8'hA5, frame_error_o = 0, parity_error_o = 0.
- 7E1, 0x35 with parity bit 0 -> data_rx_o = 8'h35, no errors. Same frame with parity bit 1 -> parity_error_o = 1 with rx_done_o.
- 5O2, 0x1B followed immediately by 0x04 (no idle gap) -> two rx_done_o pulses; data_rx_o = 8'h1B then 8'h04; parity bit per odd rule; no errors.
- 8N1, 0x3C with stop bit driven 0 -> rx_done_o = 1, frame_error_o = 1, data_rx_o = 8'h3C. Line held low afterwards -> no further rx_done_o until a high-to-low edge.
- Line low for 4 ticks then high -> rx_busy_o pulses then drops at the mid-start sample, no rx_done_o. Next valid 8N1 0x81 -> data_rx_o = 8'h81.
- rst_i for one cycle during data bit 3 of 0xFF, then a clean 8N1 0x42 -> no pulse for 0xFF, outputs at reset values, data_rx_o = 8'h42 after the second frame. Separately, rx_enable_i dropped mid-frame -> abort, no pulse.

Source files
------------

// File: rtl/uart_rx_if.sv
// UART receive bundle: serial line, config and character outputs.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must take each rx_done_o pulse when it occurs.
interface uart_rx_if;
    logic       rx_i;
    logic       rx_enable_i;
    logic       ov_tick_i;
    logic [1:0] data_width_i;
    logic [1:0] parity_mode_i;
    logic       stop_bits_i;
    logic [7:0] data_rx_o;
    logic       rx_done_o;
    logic       frame_error_o;
    logic       parity_error_o;
    logic       rx_busy_o;

    modport master (
        output rx_i, rx_enable_i, ov_tick_i, data_width_i, parity_mode_i, stop_bits_i,
        input  data_rx_o, rx_done_o, frame_error_o, parity_error_o, rx_busy_o
    );

    modport slave (
        input  rx_i, rx_enable_i, ov_tick_i, data_width_i, parity_mode_i, stop_bits_i,
        output data_rx_o, rx_done_o, frame_error_o, parity_error_o, rx_busy_o
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: synchronises rx, finds the start bit, samples mid-bit on the 16x tick.
// Latency: (1+N+P+S)*OVERSAMPLE - OVERSAMPLE/2 ticks from start edge, +1 clock, + sync stages.
// Backpressure: none; each character is announced by a single-cycle rx_done_o pulse.
module uart_receiver #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic       clk_i,
    input logic       rst_i,
    uart_rx_if.slave  bus
);
    localparam int              CW      = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]   HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]   LAST    = CW'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q;
    logic                   rx_s;
    logic                   fall;

    logic [2:0]    state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [2:0]    bit_q,     bit_d;
    logic [7:0]    shreg_q,   shreg_d;
    logic          par_acc_q, par_acc_d;
    logic          ferr_q,    ferr_d;
    logic          perr_q,    perr_d;
    logic [1:0]    width_q,   width_d;
    logic [1:0]    pmode_q,   pmode_d;
    logic          stop2_q,   stop2_d;
    logic [7:0]    data_rx_q, data_rx_d;
    logic          done_q,    done_d;
    logic          fe_q,      fe_d;
    logic          pe_q,      pe_d;

    logic [2:0] last_idx;
    logic       parity_en;
    logic       parity_odd;

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign fall       = rx_prev_q & ~rx_s;
    assign last_idx   = 3'd4 + {1'b0, width_q};
    assign parity_en  = (pmode_q == 2'b01) || (pmode_q == 2'b10);
    assign parity_odd = (pmode_q == 2'b10);

    // Bring the asynchronous line into clk_i domain and keep a delayed copy for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.rx_i};
            rx_prev_q <= rx_s;
        end
    end

    // Frame FSM: every sample point is a tick where the counter hits its mid/wrap value.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_acc_d = par_acc_q;
        ferr_d    = ferr_q;
        perr_d    = perr_q;
        width_d   = width_q;
        pmode_d   = pmode_q;
        stop2_d   = stop2_q;
        data_rx_d = data_rx_q;
        done_d    = 1'b0;
        fe_d      = 1'b0;
        pe_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall && bus.rx_enable_i) begin
                    width_d = bus.data_width_i;
                    pmode_d = bus.parity_mode_i;
                    stop2_d = bus.stop_bits_i;
                    cnt_d   = '0;
                    ferr_d  = 1'b0;
                    perr_d  = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bus.ov_tick_i) begin
                    if (cnt_q == HALF_M1) begin
                        if (!rx_s) begin
                            cnt_d     = '0;
                            bit_d     = '0;
                            shreg_d   = '0;
                            par_acc_d = 1'b0;
                            state_d   = S_DATA;
                        end else begin
                            // Line back high at mid-start: treat as a glitch.
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (bus.ov_tick_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        shreg_d[bit_q] = rx_s;
                        par_acc_d      = par_acc_q ^ rx_s;
                        if (bit_q == last_idx) begin
                            bit_d   = '0;
                            state_d = parity_en ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
            end
            S_PARITY: begin
                if (bus.ov_tick_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        if (rx_s != (par_acc_q ^ parity_odd)) perr_d = 1'b1;
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (bus.ov_tick_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        if (!rx_s) ferr_d = 1'b1;
                        if (stop2_q && (bit_q == 3'd0)) begin
                            // First of two stop bits; the second is sampled regardless.
                            bit_d = 3'd1;
                        end else begin
                            data_rx_d = shreg_q;
                            done_d    = 1'b1;
                            fe_d      = ferr_q | ~rx_s;
                            pe_d      = perr_q;
                            state_d   = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Disabling the receiver mid-frame drops the character silently.
        if ((state_q != S_IDLE) && !bus.rx_enable_i) begin
            state_d   = S_IDLE;
            data_rx_d = data_rx_q;
            done_d    = 1'b0;
            fe_d      = 1'b0;
            pe_d      = 1'b0;
        end
    end

    // Register all FSM state, latched config and the published outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_acc_q <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            width_q   <= '0;
            pmode_q   <= '0;
            stop2_q   <= 1'b0;
            data_rx_q <= '0;
            done_q    <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            par_acc_q <= par_acc_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            width_q   <= width_d;
            pmode_q   <= pmode_d;
            stop2_q   <= stop2_d;
            data_rx_q <= data_rx_d;
            done_q    <= done_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
        end
    end

    assign bus.data_rx_o      = data_rx_q;
    assign bus.rx_done_o      = done_q;
    assign bus.frame_error_o  = fe_q;
    assign bus.parity_error_o = pe_q;
    assign bus.rx_busy_o      = (state_q != S_IDLE);
endmodule
